// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
// The REGFILE_BYPASS_EN macro (see register_file_sb) enables write-to-read forwarding.
package regfile_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int NUM_REGS   = 16;
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  // Write-port index; higher index wins on an address collision.
  typedef enum logic {WP_ALU = 1'b0, WP_LD = 1'b1} wport_e;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one pending bit per register, a popcount-tracking
// counter and a per-read-port ready lookup.
module reg_scoreboard import regfile_pkg::*; #(
  parameter int NumRegs      = NUM_REGS,
  parameter int NumReadPorts = 2,
  parameter int AddrWidth    = $clog2(NumRegs)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    set_en,
  input  logic [AddrWidth-1:0]                    set_addr,
  input  logic                                    clr_en,
  input  logic [AddrWidth-1:0]                    clr_addr,
  input  logic [NumReadPorts-1:0][AddrWidth-1:0]  rd_addr,
  output logic [NumReadPorts-1:0]                 rd_ready,
  output logic [AddrWidth:0]                      pend_cnt
);
  logic [NumRegs-1:0] pending, pending_nxt;
  logic [AddrWidth:0] cnt_nxt;
  logic               set_new, clr_hit;

  always_comb begin
    // A new issue on the completing register keeps it pending.
    set_new     = set_en && !pending[set_addr];
    clr_hit     = clr_en && pending[clr_addr] && !(set_en && (set_addr == clr_addr));
    pending_nxt = pending;
    if (clr_hit) pending_nxt[clr_addr] = 1'b0;
    if (set_en)  pending_nxt[set_addr] = 1'b1;
    cnt_nxt = pend_cnt;
    case ({set_new, clr_hit})
      2'b10:   cnt_nxt = pend_cnt + (AddrWidth+1)'(1);
      2'b01:   cnt_nxt = pend_cnt - (AddrWidth+1)'(1);
      default: cnt_nxt = pend_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    rd_ready = '0;
    for (int p = 0; p < NumReadPorts; p++) rd_ready[p] = ~pending[rd_addr[p]];
  end
endmodule

// File: rtl/register_file_sb.sv
// Multi-read register file with ALU and load writeback ports plus pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module register_file_sb import regfile_pkg::*; #(
  parameter  int DataWidth    = DATA_WIDTH,
  parameter  int NumRegs      = NUM_REGS,
  parameter  int NumReadPorts = 2,
  localparam int AddrWidth    = $clog2(NumRegs)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    alu_w_en,
  input  logic [AddrWidth-1:0]                    alu_w_addr,
  input  logic [DataWidth-1:0]                    alu_w_data,
  input  logic                                    ld_w_en,
  input  logic [AddrWidth-1:0]                    ld_w_addr,
  input  logic [DataWidth-1:0]                    ld_w_data,
  input  logic                                    pend_set_en,
  input  logic [AddrWidth-1:0]                    pend_set_addr,
  input  logic [NumReadPorts-1:0][AddrWidth-1:0]  rd_addr,
  output logic [NumReadPorts-1:0][DataWidth-1:0]  rd_data,
  output logic [NumReadPorts-1:0]                 rd_ready,
  output logic [AddrWidth:0]                      pend_cnt
);
  typedef struct packed {
    logic                 en;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
  } wreq_t;

  wreq_t [1:0]                      wr;
  logic  [NumRegs-1:0][DataWidth-1:0] regs;
  logic  [NumReadPorts-1:0]         sb_ready;

  assign wr[WP_ALU] = '{en: alu_w_en, addr: alu_w_addr, data: alu_w_data};
  assign wr[WP_LD]  = '{en: ld_w_en,  addr: ld_w_addr,  data: ld_w_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      // ALU result is dropped when the load lands on the same register.
      if (wr[WP_ALU].en && !(wr[WP_LD].en && (wr[WP_LD].addr == wr[WP_ALU].addr)))
        regs[wr[WP_ALU].addr] <= wr[WP_ALU].data;
      if (wr[WP_LD].en)
        regs[wr[WP_LD].addr] <= wr[WP_LD].data;
    end
  end

  reg_scoreboard #(
    .NumRegs      (NumRegs),
    .NumReadPorts (NumReadPorts),
    .AddrWidth    (AddrWidth)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (pend_set_en),
    .set_addr (pend_set_addr),
    .clr_en   (ld_w_en),
    .clr_addr (ld_w_addr),
    .rd_addr  (rd_addr),
    .rd_ready (sb_ready),
    .pend_cnt (pend_cnt)
  );

  always_comb begin
    rd_data  = '0;
    rd_ready = sb_ready;
    for (int p = 0; p < NumReadPorts; p++) begin
      rd_data[p] = regs[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr[WP_LD].en && (wr[WP_LD].addr == rd_addr[p])) begin
        rd_data[p] = wr[WP_LD].data;
        if (!(pend_set_en && (pend_set_addr == rd_addr[p]))) rd_ready[p] = 1'b1;
      end else if (wr[WP_ALU].en && (wr[WP_ALU].addr == rd_addr[p])) begin
        rd_data[p] = wr[WP_ALU].data;
      end
`endif
    end
  end
endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb (default 16x16, two read ports).
module tb_register_file_sb;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_w_en, ld_w_en, pend_set_en;
  logic [3:0]      alu_w_addr, ld_w_addr, pend_set_addr;
  logic [15:0]     alu_w_data, ld_w_data;
  logic [1:0][3:0] rd_addr;
  logic [1:0][15:0] rd_data;
  logic [1:0]      rd_ready;
  logic [4:0]      pend_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_file_sb dut (
    .clk(clk), .rst(rst),
    .alu_w_en(alu_w_en), .alu_w_addr(alu_w_addr), .alu_w_data(alu_w_data),
    .ld_w_en(ld_w_en), .ld_w_addr(ld_w_addr), .ld_w_data(ld_w_data),
    .pend_set_en(pend_set_en), .pend_set_addr(pend_set_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready), .pend_cnt(pend_cnt)
  );

  // Advance past the next edge and drop all write/issue strobes.
  task automatic step();
    @(posedge clk); #1;
    alu_w_en = 1'b0; ld_w_en = 1'b0; pend_set_en = 1'b0;
  endtask

  task automatic alu(input logic [3:0] a, input logic [15:0] d);
    alu_w_en = 1'b1; alu_w_addr = a; alu_w_data = d;
  endtask

  task automatic ld(input logic [3:0] a, input logic [15:0] d);
    ld_w_en = 1'b1; ld_w_addr = a; ld_w_data = d;
  endtask

  task automatic pset(input logic [3:0] a);
    pend_set_en = 1'b1; pend_set_addr = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_w_en = 1'b0; ld_w_en = 1'b0; pend_set_en = 1'b0;
    alu_w_addr = '0; ld_w_addr = '0; pend_set_addr = '0;
    alu_w_data = '0; ld_w_data = '0;
    rd_addr[0] = 4'd3; rd_addr[1] = 4'd9;
    #1;
    n_cmp++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h expected 0", rd_data); end
    n_cmp++; if (rd_ready !== 2'b11) begin n_err++; $display("FAIL rst_ready: got %b expected 11", rd_ready); end
    n_cmp++; if (pend_cnt !== 5'd0) begin n_err++; $display("FAIL rst_cnt: got %0d expected 0", pend_cnt); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    alu(4'd3, 16'hBEEF); pset(4'd9);
    step();
    n_cmp++; if (rd_data[0] !== 16'hBEEF) begin n_err++; $display("FAIL pre_rst_r3: got %h expected beef", rd_data[0]); end
    n_cmp++; if (rd_ready !== 2'b01) begin n_err++; $display("FAIL pre_rst_ready: got %b expected 01", rd_ready); end
    n_cmp++; if (pend_cnt !== 5'd1) begin n_err++; $display("FAIL pre_rst_cnt: got %0d expected 1", pend_cnt); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (rd_data[0] !== 16'h0) begin n_err++; $display("FAIL midrst_r3: got %h expected 0", rd_data[0]); end
    n_cmp++; if (pend_cnt !== 5'd0) begin n_err++; $display("FAIL midrst_cnt: got %0d expected 0", pend_cnt); end
    n_cmp++; if (rd_ready !== 2'b11) begin n_err++; $display("FAIL midrst_ready: got %b expected 11", rd_ready); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_conflict();
    rd_addr[0] = 4'd5; rd_addr[1] = 4'd6;
    alu(4'd5, 16'h1111); ld(4'd5, 16'h2222);
    step();
    n_cmp++; if (rd_data[0] !== 16'h2222) begin n_err++; $display("FAIL conflict_r5: got %h expected 2222", rd_data[0]); end
    alu(4'd6, 16'h3333); ld(4'd8, 16'h4444);
    step();
    n_cmp++; if (rd_data[1] !== 16'h3333) begin n_err++; $display("FAIL dual_r6: got %h expected 3333", rd_data[1]); end
    rd_addr[0] = 4'd8; #1;
    n_cmp++; if (rd_data[0] !== 16'h4444) begin n_err++; $display("FAIL dual_r8: got %h expected 4444", rd_data[0]); end
    n_cmp++; if (pend_cnt !== 5'd0) begin n_err++; $display("FAIL ld_nonpend_cnt: got %0d expected 0", pend_cnt); end
  endtask

  task automatic test_scoreboard();
    rd_addr[0] = 4'd7; rd_addr[1] = 4'd8;
    pset(4'd7);
    step();
    n_cmp++; if (rd_ready !== 2'b10) begin n_err++; $display("FAIL sb_ready_set: got %b expected 10", rd_ready); end
    n_cmp++; if (pend_cnt !== 5'd1) begin n_err++; $display("FAIL sb_cnt_set: got %0d expected 1", pend_cnt); end
    ld(4'd7, 16'h00AA); #1;
    n_cmp++; if (rd_ready[0] !== BYP) begin n_err++; $display("FAIL sb_ready_fwd: got %b expected %b", rd_ready[0], BYP); end
    n_cmp++; if (rd_data[0] !== (BYP ? 16'h00AA : 16'h0000)) begin n_err++; $display("FAIL sb_data_fwd: got %h expected %h", rd_data[0], BYP ? 16'h00AA : 16'h0000); end
    step();
    n_cmp++; if (rd_ready !== 2'b11) begin n_err++; $display("FAIL sb_ready_clr: got %b expected 11", rd_ready); end
    n_cmp++; if (pend_cnt !== 5'd0) begin n_err++; $display("FAIL sb_cnt_clr: got %0d expected 0", pend_cnt); end
    n_cmp++; if (rd_data[0] !== 16'h00AA) begin n_err++; $display("FAIL sb_data_r7: got %h expected 00aa", rd_data[0]); end
    rd_addr[0] = 4'd1;
    pset(4'd1);
    step();
    alu(4'd1, 16'h7777);
    step();
    n_cmp++; if (rd_ready[0] !== 1'b0) begin n_err++; $display("FAIL alu_keeps_pend: got %b expected 0", rd_ready[0]); end
    n_cmp++; if (pend_cnt !== 5'd1) begin n_err++; $display("FAIL alu_cnt: got %0d expected 1", pend_cnt); end
    n_cmp++; if (rd_data[0] !== 16'h7777) begin n_err++; $display("FAIL alu_data_r1: got %h expected 7777", rd_data[0]); end
    ld(4'd1, 16'h7778);
    step();
    n_cmp++; if (pend_cnt !== 5'd0) begin n_err++; $display("FAIL r1_clr_cnt: got %0d expected 0", pend_cnt); end
  endtask

  task automatic test_set_clear();
    rd_addr[0] = 4'd2; rd_addr[1] = 4'd3;
    pset(4'd2);
    step();
    n_cmp++; if (pend_cnt !== 5'd1) begin n_err++; $display("FAIL sc_cnt_pre: got %0d expected 1", pend_cnt); end
    pset(4'd2); ld(4'd2, 16'h5A5A); #1;
    n_cmp++; if (rd_ready[0] !== 1'b0) begin n_err++; $display("FAIL sc_ready_same: got %b expected 0", rd_ready[0]); end
    step();
    n_cmp++; if (rd_ready[0] !== 1'b0) begin n_err++; $display("FAIL sc_still_pend: got %b expected 0", rd_ready[0]); end
    n_cmp++; if (pend_cnt !== 5'd1) begin n_err++; $display("FAIL sc_cnt: got %0d expected 1", pend_cnt); end
    n_cmp++; if (rd_data[0] !== 16'h5A5A) begin n_err++; $display("FAIL sc_data: got %h expected 5a5a", rd_data[0]); end
    pset(4'd3); ld(4'd2, 16'h6B6B);
    step();
    n_cmp++; if (rd_ready !== 2'b01) begin n_err++; $display("FAIL swap_ready: got %b expected 01", rd_ready); end
    n_cmp++; if (pend_cnt !== 5'd1) begin n_err++; $display("FAIL swap_cnt: got %0d expected 1", pend_cnt); end
    ld(4'd3, 16'h0033);
    step();
    n_cmp++; if (pend_cnt !== 5'd0) begin n_err++; $display("FAIL swap_clr_cnt: got %0d expected 0", pend_cnt); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      pset(4'(i));
      step();
      n_cmp++; if (pend_cnt !== 5'(i + 1)) begin n_err++; $display("FAIL fill_cnt_%0d: got %0d expected %0d", i, pend_cnt, i + 1); end
    end
    pset(4'd0);
    step();
    n_cmp++; if (pend_cnt !== 5'd16) begin n_err++; $display("FAIL fill_reset_r0: got %0d expected 16", pend_cnt); end
    rd_addr[0] = 4'd0; rd_addr[1] = 4'd15; #1;
    n_cmp++; if (rd_ready !== 2'b00) begin n_err++; $display("FAIL fill_ready: got %b expected 00", rd_ready); end
    for (int i = 0; i < 16; i++) begin
      ld(4'(i), 16'(16'h0100 + i));
      step();
      n_cmp++; if (pend_cnt !== 5'(15 - i)) begin n_err++; $display("FAIL drain_cnt_%0d: got %0d expected %0d", i, pend_cnt, 15 - i); end
    end
    n_cmp++; if (rd_data[1] !== 16'h010F) begin n_err++; $display("FAIL drain_r15: got %h expected 010f", rd_data[1]); end
  endtask

  task automatic test_bypass();
    rd_addr[0] = 4'd0; rd_addr[1] = 4'd4;
    alu(4'd4, 16'h0F0F);
    step();
    alu(4'd4, 16'h1234); #1;
    n_cmp++; if (rd_data[1] !== (BYP ? 16'h1234 : 16'h0F0F)) begin n_err++; $display("FAIL byp_alu: got %h expected %h", rd_data[1], BYP ? 16'h1234 : 16'h0F0F); end
    n_cmp++; if (rd_data[0] !== 16'h0100) begin n_err++; $display("FAIL byp_other_port: got %h expected 0100", rd_data[0]); end
    step();
    n_cmp++; if (rd_data[1] !== 16'h1234) begin n_err++; $display("FAIL byp_alu_next: got %h expected 1234", rd_data[1]); end
    alu(4'd4, 16'hAAAA); ld(4'd4, 16'hBBBB); #1;
    n_cmp++; if (rd_data[1] !== (BYP ? 16'hBBBB : 16'h1234)) begin n_err++; $display("FAIL byp_ld_wins: got %h expected %h", rd_data[1], BYP ? 16'hBBBB : 16'h1234); end
    step();
    n_cmp++; if (rd_data[1] !== 16'hBBBB) begin n_err++; $display("FAIL byp_ld_next: got %h expected bbbb", rd_data[1]); end
  endtask

  initial begin
    test_reset();
    test_conflict();
    test_scoreboard();
    test_set_clear();
    test_fill();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
